prog_clock_divider: RTL and testbench
=====================================

Name: prog_clock_divider

Overview:
- Multi-channel, runtime-programmable clock divider for the elevator controller.
- Generates NUM_CH independent slow square waves from clkIn, plus a one-cycle tick strobe per channel (e.g. floor-travel timer, door timer, display scan).
- Each channel's half-period is reprogrammable through a valid/ready config port. Updates take effect only at a toggle boundary, so no runt pulses occur.

Parameters:
- NUM_CH, 2, number of independent divider channels (1..8).
- CNT_W, 32, width of per-channel counter and half-period value.
- DEF_HALF, 25_000_000, half-period loaded into every channel at reset.

Ports:
- clkIn  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- en  in  NUM_CH  per-channel run enable.
- cfg_valid  in  1  config request strobe.
- cfg_ch  in  $clog2(NUM_CH) (min 1)  target channel index.
- cfg_half  in  CNT_W  new half-period value H.
- cfg_ready  out  1  config can be accepted this cycle.
- clkOut  out  NUM_CH  divided clock per channel.
- tick  out  NUM_CH  one-cycle pulse on each rising edge of clkOut[i].
- sync_all  in  1  only present with PHASE_SYNC_EN.

Behaviour:
- Reset (async, any time, including mid-update) sets, per channel:
  - cnt=0, clkOut=0, tick=0, active_half=DEF_HALF, pending=0.
- Per channel with en[i]=1, every clkIn rising edge:
  - If cnt==active_half: cnt<=0 and clkOut[i] toggles (the toggle event).
  - Otherwise cnt<=cnt+1.
- Output period is 2*(H+1) clkIn cycles with 50% duty. H=0 gives divide-by-2.
- tick[i]=1 for exactly the cycle after a 0->1 toggle, i.e. registered, coincident with clkOut[i] first being high. It is never asserted on a 1->0 toggle.
- en[i]=0:
  - cnt and clkOut[i] hold; tick[i]=0.
  - Re-enabling resumes from the held count.
- Config handshake:
  - Transfer occurs when cfg_valid && cfg_ready on a clkIn edge.
  - cfg_ready = ~pending[cfg_ch] (combinational on cfg_ch).
  - On transfer: staged_half[cfg_ch]<=cfg_half and pending[cfg_ch]<=1.
- Applying a pending update:
  - en[i]=1: applied on the next toggle event of channel i. That same edge loads active_half<=staged_half, clears pending, and sets cnt<=0. The half-cycle in progress completes with the old value.
  - en[i]=0: applied on the next edge. Sets active_half, clears pending, cnt<=0, clkOut unchanged.
- Simultaneous toggle event and transfer to the same channel cannot occur, because ready is low while pending. A transfer to a different channel is independent.
- cfg_ch >= NUM_CH:
  - cfg_ready=1 and the transfer is accepted and discarded (no channel changes).
- Counter arithmetic: unsigned, CNT_W bits. cnt never exceeds active_half, so no wrap is possible.

Optional Feature:
- Macro PHASE_SYNC_EN.
- Defined:
  - Adds input sync_all.
  - sync_all=1 on an edge sets every channel's cnt=0 and clkOut=0, and sets tick=0.
  - Pending updates are applied immediately on that edge.
  - sync_all has priority over enable and config; a config transfer in the same cycle is still captured as pending.
- Undefined: port absent; channels free-run independently.

Decomposition:
- Package clk_div_pkg holds:
  - CNT_W default and DEF_HALF constant.
  - ch_idx_t typedef.
  - function half_for_hz(clk_hz, out_hz) returning clk_hz/(2*out_hz)-1.
- Sub-module clk_div_channel:
  - Holds cnt, clkOut, tick, active_half, staged_half, pending.
  - Has load strobe and en inputs.
  - Instantiated NUM_CH times by a generate loop.
  - The top module does only cfg_ch decode and the cfg_ready mux.

Test Plan:
- Reset, DEF_HALF overridden to 5, en=all 1:
  - clkOut[0] toggles every 6 cycles (period 12).
  - tick[0] is high 1 cycle per 12.
- Program ch1 H=0 while ch0 H=5:
  - ch1 becomes divide-by-2, starting at its next toggle.
  - ch0 period is unaffected.
- Program ch0 H=2 at cnt=1 of a high phase:
  - The high phase completes at 6 cycles, then the period becomes 6.
  - cfg_ready for ch0 is low from the acceptance edge until that toggle edge.
  - A second cfg_valid for ch0 is stalled during this window.
- en[0]=0 for 10 cycles mid-phase: clkOut[0] and cnt hold, tick=0, resume seamlessly.
- Assert reset with ch0 update pending and clkOut=1:
  - All outputs go 0 immediately (async).
  - pending clears; active_half=DEF_HALF.
- PHASE_SYNC_EN: ch0 H=3, ch1 H=5, pulse sync_all: both clkOut=0 and cnt=0 next edge; first rising edges occur 4 and 6 cycles later.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared constants, types and helpers for the programmable clock divider.
// Build option: define PHASE_SYNC_EN to add the sync_all phase-alignment input.
package clk_div_pkg;

    localparam int          CNT_W_DEF    = 32;
    localparam int unsigned DEF_HALF_DEF = 25_000_000;
    localparam int          MAX_CH       = 8;

    typedef logic [$clog2(MAX_CH)-1:0] ch_idx_t;

    // Half-period value that makes a channel run at outHz from a clkHz source.
    function automatic logic [CNT_W_DEF-1:0] half_for_hz(input longint unsigned clkHz,
                                                         input longint unsigned outHz);
        longint unsigned half;
        half = clkHz / (2 * outHz) - 1;
        return half[CNT_W_DEF-1:0];
    endfunction

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: counter, output level, tick strobe and staged half-period update.
// With PHASE_SYNC_EN defined, sync_i forces the channel back to phase zero.
module clk_div_channel
    import clk_div_pkg::*;
#(
    parameter int          CNT_W    = CNT_W_DEF,
    parameter int unsigned DEF_HALF = DEF_HALF_DEF
) (
    input  logic             clkIn,
    input  logic             reset,
`ifdef PHASE_SYNC_EN
    input  logic             sync_i,
`endif
    input  logic             en_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] half_i,
    output logic             clkOut_o,
    output logic             tick_o,
    output logic             pending_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] activeHalf_q, activeHalf_d;
    logic [CNT_W-1:0] stagedHalf_q, stagedHalf_d;
    logic             clkOut_q, clkOut_d;
    logic             tick_q, tick_d;
    logic             pending_q, pending_d;

    // A staged value only becomes active on a toggle edge, while idle, or on sync.
    always_comb begin
        cnt_d        = cnt_q;
        activeHalf_d = activeHalf_q;
        stagedHalf_d = stagedHalf_q;
        clkOut_d     = clkOut_q;
        tick_d       = 1'b0;
        pending_d    = pending_q;
`ifdef PHASE_SYNC_EN
        if (sync_i) begin
            cnt_d    = '0;
            clkOut_d = 1'b0;
            if (pending_q) begin
                activeHalf_d = stagedHalf_q;
                pending_d    = 1'b0;
            end
        end else
`endif
        if (en_i) begin
            if (cnt_q == activeHalf_q) begin
                cnt_d    = '0;
                clkOut_d = ~clkOut_q;
                tick_d   = ~clkOut_q;
                if (pending_q) begin
                    activeHalf_d = stagedHalf_q;
                    pending_d    = 1'b0;
                end
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (pending_q) begin
            cnt_d        = '0;
            activeHalf_d = stagedHalf_q;
            pending_d    = 1'b0;
        end
        if (load_i && !pending_q) begin
            stagedHalf_d = half_i;
            pending_d    = 1'b1;
        end
    end

    always_ff @(posedge clkIn or posedge reset) begin
        if (reset) begin
            cnt_q        <= '0;
            activeHalf_q <= CNT_W'(DEF_HALF);
            stagedHalf_q <= CNT_W'(DEF_HALF);
            clkOut_q     <= 1'b0;
            tick_q       <= 1'b0;
            pending_q    <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            activeHalf_q <= activeHalf_d;
            stagedHalf_q <= stagedHalf_d;
            clkOut_q     <= clkOut_d;
            tick_q       <= tick_d;
            pending_q    <= pending_d;
        end
    end

    assign clkOut_o  = clkOut_q;
    assign tick_o    = tick_q;
    assign pending_o = pending_q;

endmodule

// File: rtl/prog_clock_divider.sv
// Multi-channel runtime-programmable clock divider: config decode plus NUM_CH channels.
// Build option: define PHASE_SYNC_EN to add the sync_all input.
module prog_clock_divider
    import clk_div_pkg::*;
#(
    parameter int          NUM_CH   = 2,
    parameter int          CNT_W    = CNT_W_DEF,
    parameter int unsigned DEF_HALF = DEF_HALF_DEF,
    localparam int         CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clkIn,
    input  logic              reset,
`ifdef PHASE_SYNC_EN
    input  logic              sync_all,
`endif
    input  logic [NUM_CH-1:0] en,
    input  logic              cfg_valid,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_half,
    output logic              cfg_ready,
    output logic [NUM_CH-1:0] clkOut,
    output logic [NUM_CH-1:0] tick
);

    logic [NUM_CH-1:0] pending;
    logic [NUM_CH-1:0] load;

    // Out-of-range channel indices stay ready so the request is swallowed.
    always_comb begin
        cfg_ready = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cfg_ch == CH_W'(i)) begin
                cfg_ready = ~pending[i];
            end
        end
    end

    always_comb begin
        load = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            load[i] = cfg_valid && cfg_ready && (cfg_ch == CH_W'(i));
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : gCh
        clk_div_channel #(
            .CNT_W    (CNT_W),
            .DEF_HALF (DEF_HALF)
        ) uChannel (
            .clkIn     (clkIn),
            .reset     (reset),
`ifdef PHASE_SYNC_EN
            .sync_i    (sync_all),
`endif
            .en_i      (en[g]),
            .load_i    (load[g]),
            .half_i    (cfg_half),
            .clkOut_o  (clkOut[g]),
            .tick_o    (tick[g]),
            .pending_o (pending[g])
        );
    end

endmodule

// File: tb/tb_prog_clock_divider.sv
// Randomized self-checking bench for prog_clock_divider against a countdown reference model.
// Honors PHASE_SYNC_EN when the design is built with it.
module tb_prog_clock_divider;

    localparam int NCH   = 3;
    localparam int CW    = 32;
    localparam int DEFH  = 5;
    localparam int CHW   = 2;
    localparam int NCYC  = 3000;

    logic           clkIn = 1'b0;
    logic           reset = 1'b1;
    logic [NCH-1:0] en = '0;
    logic           cfg_valid = 1'b0;
    logic [CHW-1:0] cfg_ch = '0;
    logic [CW-1:0]  cfg_half = '0;
    logic           cfg_ready;
    logic [NCH-1:0] clkOut;
    logic [NCH-1:0] tick;
`ifdef PHASE_SYNC_EN
    logic           sync_all = 1'b0;
`endif

    int total = 0;
    int bad   = 0;

    // Reference model: cycles left until the next toggle, output level, active and staged half.
    int remain [NCH];
    bit level  [NCH];
    bit tk     [NCH];
    int hAct   [NCH];
    int hStg   [NCH];
    bit pend   [NCH];

    prog_clock_divider #(
        .NUM_CH   (NCH),
        .CNT_W    (CW),
        .DEF_HALF (DEFH)
    ) dut (
        .clkIn     (clkIn),
        .reset     (reset),
`ifdef PHASE_SYNC_EN
        .sync_all  (sync_all),
`endif
        .en        (en),
        .cfg_valid (cfg_valid),
        .cfg_ch    (cfg_ch),
        .cfg_half  (cfg_half),
        .cfg_ready (cfg_ready),
        .clkOut    (clkOut),
        .tick      (tick)
    );

    always #5 clkIn = ~clkIn;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < NCH; i++) begin
            remain[i] = DEFH + 1;
            level[i]  = 1'b0;
            tk[i]     = 1'b0;
            hAct[i]   = DEFH;
            hStg[i]   = DEFH;
            pend[i]   = 1'b0;
        end
    endtask

    function automatic logic modelReady(input int ch);
        if (ch >= NCH) return 1'b1;
        return !pend[ch];
    endfunction

    function automatic logic [NCH-1:0] expClk();
        logic [NCH-1:0] v;
        for (int i = 0; i < NCH; i++) v[i] = level[i];
        return v;
    endfunction

    function automatic logic [NCH-1:0] expTick();
        logic [NCH-1:0] v;
        for (int i = 0; i < NCH; i++) v[i] = tk[i];
        return v;
    endfunction

    // Advance the model by one clkIn edge using the inputs currently driven.
    task automatic modelStep();
        bit xfer;
        bit syncNow;
        int ch;
        ch      = int'(cfg_ch);
        xfer    = cfg_valid && modelReady(ch);
        syncNow = 1'b0;
`ifdef PHASE_SYNC_EN
        syncNow = sync_all;
`endif
        for (int i = 0; i < NCH; i++) begin
            tk[i] = 1'b0;
            if (syncNow) begin
                level[i] = 1'b0;
                if (pend[i]) begin
                    hAct[i] = hStg[i];
                    pend[i] = 1'b0;
                end
                remain[i] = hAct[i] + 1;
            end else if (en[i]) begin
                remain[i]--;
                if (remain[i] == 0) begin
                    level[i] = !level[i];
                    tk[i]    = level[i];
                    if (pend[i]) begin
                        hAct[i] = hStg[i];
                        pend[i] = 1'b0;
                    end
                    remain[i] = hAct[i] + 1;
                end
            end else if (pend[i]) begin
                hAct[i]   = hStg[i];
                pend[i]   = 1'b0;
                remain[i] = hAct[i] + 1;
            end
        end
        if (xfer && ch < NCH) begin
            hStg[ch] = int'(cfg_half);
            pend[ch] = 1'b1;
        end
    endtask

    task automatic applyStimulus();
        for (int i = 0; i < NCH; i++) en[i] = ($urandom_range(0, 9) != 0);
        cfg_valid = ($urandom_range(0, 9) < 3);
        cfg_ch    = CHW'($urandom_range(0, 3));
        cfg_half  = CW'($urandom_range(0, 7));
`ifdef PHASE_SYNC_EN
        sync_all  = ($urandom_range(0, 49) == 0);
`endif
    endtask

    initial begin
        modelReset();
        repeat (2) @(negedge clkIn);
        checkOutput("resetClkOut", clkOut, '0);
        checkOutput("resetTick", tick, '0);
        checkOutput("resetReady", cfg_ready, 1'b1);
        reset = 1'b0;
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clkIn);
            checkOutput("clkOut", clkOut, expClk());
            checkOutput("tick", tick, expTick());
            if (cyc % 700 == 350) begin
                reset = 1'b1;
                #1;
                checkOutput("asyncRstClkOut", clkOut, '0);
                checkOutput("asyncRstTick", tick, '0);
                modelReset();
                #1 reset = 1'b0;
            end
            applyStimulus();
            #1;
            checkOutput("cfgReady", cfg_ready, modelReady(int'(cfg_ch)));
            modelStep();
        end
        @(negedge clkIn);
        checkOutput("finalClkOut", clkOut, expClk());
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
